// File: rtl/l2_sa_cache_lru_pkg.sv
// Shared types for the L2 set-associative cache: MESI line state, request opcodes.
package l2_sa_cache_lru_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } CacheState;

  typedef enum logic [1:0] {
    READ       = 2'b00,
    WRITE      = 2'b01,
    INVALIDATE = 2'b10,
    RSVD       = 2'b11
  } l2_op_t;

  // A line needs writing back before eviction only when it holds modified data.
  function automatic logic is_dirty_state(CacheState s);
    return s == MODIFIED;
  endfunction

endpackage

// File: rtl/l2_sa_cache_lru_victim_select.sv
// Per-set replacement helper: picks a victim way and computes true-LRU ages after a touch.
module l2_victim_select #(
  parameter int unsigned WAYS = 4,
  localparam int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS*AGE_W-1:0] ages,
  input  logic [AGE_W-1:0]      touch_way,
  output logic [AGE_W-1:0]      victim_way,
  output logic                  victim_is_invalid,
  output logic [WAYS*AGE_W-1:0] touched_ages
);

  logic [AGE_W-1:0] oldest_way;
  logic [AGE_W-1:0] invalid_way;
  logic [AGE_W-1:0] touch_age;

  // Lowest-index invalid way wins; otherwise the way whose age is WAYS-1.
  always_comb begin
    invalid_way       = '0;
    oldest_way        = '0;
    victim_is_invalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        invalid_way       = AGE_W'(w);
        victim_is_invalid = 1'b1;
      end
      if (ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
        oldest_way = AGE_W'(w);
      end
    end
    victim_way = victim_is_invalid ? invalid_way : oldest_way;
  end

  // Touch: ways younger than the touched way age by one, touched way becomes 0.
  always_comb begin
    touch_age    = '0;
    touched_ages = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_way) begin
        touch_age = ages[w*AGE_W +: AGE_W];
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_way) begin
        touched_ages[w*AGE_W +: AGE_W] = '0;
      end else if (ages[w*AGE_W +: AGE_W] < touch_age) begin
        touched_ages[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] + AGE_W'(1);
      end else begin
        touched_ages[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W];
      end
    end
  end

endmodule

// File: rtl/l2_sa_cache_lru.sv
// L2 set-associative cache with per-line MESI state, true-LRU replacement and
// dirty-victim writeback over a valid/ready port.
module l2_sa_cache_lru
  import l2_sa_cache_lru_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BLOCK_BITS-1:0] req_data,
  input  CacheState             req_mesi,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [BLOCK_BITS-1:0] resp_data,
  output CacheState             resp_mesi,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [BLOCK_BITS-1:0] wb_data
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, INSTALL} fsm_t;

  fsm_t                  state;
  l2_op_t                op_q;
  logic [LINE_W-1:0]     line_addr_q;
  logic [BLOCK_BITS-1:0] wdata_q;
  CacheState             mesi_q;
  logic [AGE_W-1:0]      victim_q;

  // Line storage, one array per field.
  logic                  line_valid [WAYS][SETS];
  logic                  line_dirty [WAYS][SETS];
  CacheState             line_state [WAYS][SETS];
  logic [TAG_W-1:0]      line_tag   [WAYS][SETS];
  logic [BLOCK_BITS-1:0] line_data  [WAYS][SETS];
  logic [AGE_W-1:0]      line_age   [WAYS][SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic [AGE_W-1:0]      hit_way;
  logic [WAYS-1:0]       set_valid;
  logic [WAYS*AGE_W-1:0] set_ages;
  logic [AGE_W-1:0]      vs_way;
  logic                  vs_invalid;
  logic [WAYS*AGE_W-1:0] touched_ages;
  logic [AGE_W-1:0]      line_way;
  logic                  data_we;
  logic                  age_we;
  logic                  miss_victim_dirty;
  logic                  unused_offset;

  assign idx           = line_addr_q[IDX_W-1:0];
  assign tag           = line_addr_q[LINE_W-1 -: TAG_W];
  assign unused_offset = ^req_addr[OFF_W-1:0];

  // Tag compare across the ways of the latched set, plus the set's replacement view.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    set_ages  = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w]                = line_valid[w][idx];
      set_ages[w*AGE_W +: AGE_W]  = line_age[w][idx];
      if (line_valid[w][idx] && (line_tag[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  l2_victim_select #(.WAYS(WAYS)) u_victim_select (
    .valid             (set_valid),
    .ages              (set_ages),
    .touch_way         (line_way),
    .victim_way        (vs_way),
    .victim_is_invalid (vs_invalid),
    .touched_ages      (touched_ages)
  );

  assign miss_victim_dirty = !vs_invalid && line_dirty[vs_way][idx];

  // Which way is written / touched this cycle.
  always_comb begin
    data_we  = 1'b0;
    age_we   = 1'b0;
    line_way = hit_way;
    if (state == LOOKUP && hit && (op_q == READ || op_q == WRITE)) begin
      age_we = 1'b1;
    end
    if (state == LOOKUP && hit && op_q == WRITE) begin
      data_we = 1'b1;
    end
    if (state == INSTALL) begin
      data_we  = 1'b1;
      age_we   = 1'b1;
      line_way = victim_q;
    end
  end

  // Tag and block payload; no reset needed since valid gates their use.
  always_ff @(posedge clk) begin
    if (!reset && data_we) begin
      line_tag[line_way][idx]  <= tag;
      line_data[line_way][idx] <= wdata_q;
    end
  end

  // Controller FSM with registered handshake/response outputs and line metadata.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_data   <= '0;
      resp_mesi   <= INVALID;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      op_q        <= READ;
      line_addr_q <= '0;
      wdata_q     <= '0;
      mesi_q      <= INVALID;
      victim_q    <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          line_valid[w][s] <= 1'b0;
          line_dirty[w][s] <= 1'b0;
          line_state[w][s] <= INVALID;
          line_age[w][s]   <= AGE_W'(w);
        end
      end
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
      resp_mesi  <= INVALID;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            op_q        <= l2_op_t'(req_op);
            line_addr_q <= req_addr[ADDR_W-1:OFF_W];
            wdata_q     <= req_data;
            mesi_q      <= req_mesi;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          case (op_q)
            READ: begin
              resp_valid <= 1'b1;
              resp_hit   <= hit;
              if (hit) begin
                resp_data <= line_data[hit_way][idx];
                resp_mesi <= line_state[hit_way][idx];
              end
              req_ready <= 1'b1;
              state     <= IDLE;
            end
            WRITE: begin
              if (hit) begin
                line_state[hit_way][idx] <= mesi_q;
                line_dirty[hit_way][idx] <= is_dirty_state(mesi_q);
                resp_valid <= 1'b1;
                resp_hit   <= 1'b1;
                req_ready  <= 1'b1;
                state      <= IDLE;
              end else begin
                victim_q <= vs_way;
                if (miss_victim_dirty) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= {line_tag[vs_way][idx], idx, {OFF_W{1'b0}}};
                  wb_data  <= line_data[vs_way][idx];
                  state    <= WRITEBACK;
                end else begin
                  state <= INSTALL;
                end
              end
            end
            INVALIDATE: begin
              if (hit && line_dirty[hit_way][idx]) begin
                victim_q <= hit_way;
                wb_valid <= 1'b1;
                wb_addr  <= {line_tag[hit_way][idx], idx, {OFF_W{1'b0}}};
                wb_data  <= line_data[hit_way][idx];
                state    <= WRITEBACK;
              end else begin
                if (hit) begin
                  line_valid[hit_way][idx] <= 1'b0;
                  line_dirty[hit_way][idx] <= 1'b0;
                  line_state[hit_way][idx] <= INVALID;
                end
                resp_valid <= 1'b1;
                resp_hit   <= hit;
                req_ready  <= 1'b1;
                state      <= IDLE;
              end
            end
            default: begin
              resp_valid <= 1'b1;
              req_ready  <= 1'b1;
              state      <= IDLE;
            end
          endcase
        end
        WRITEBACK: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (op_q == WRITE) begin
              state <= INSTALL;
            end else begin
              line_valid[victim_q][idx] <= 1'b0;
              line_dirty[victim_q][idx] <= 1'b0;
              line_state[victim_q][idx] <= INVALID;
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              req_ready  <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        INSTALL: begin
          line_valid[victim_q][idx] <= 1'b1;
          line_state[victim_q][idx] <= mesi_q;
          line_dirty[victim_q][idx] <= is_dirty_state(mesi_q);
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (age_we) begin
        for (int w = 0; w < WAYS; w++) begin
          line_age[w][idx] <= touched_ages[w*AGE_W +: AGE_W];
        end
      end
    end
  end

endmodule
